// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-only slave driving a four-word register bank.
// Define AXIL_BRESP_EN to build the write-response channel (BVALID/BREADY/BRESP).
module axi_lite_write_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        AWVALID,
  output logic        AWREADY,
  input  logic [31:0] AWADDR,
  input  logic        WVALID,
  output logic        WREADY,
  input  logic [31:0] WDATA,
  input  logic [3:0]  WSTRB,
`ifdef AXIL_BRESP_EN
  output logic        BVALID,
  input  logic        BREADY,
  output logic [1:0]  BRESP,
`endif
  output logic [31:0] Reg0_Out,
  output logic [31:0] Reg1_Out,
  output logic [31:0] Reg2_Out,
  output logic [31:0] Reg3_Out,
  output logic [3:0]  Reg_Wr
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
`ifdef AXIL_BRESP_EN
  localparam logic [1:0] RESP  = 2'd2;
`endif

  logic [1:0]  state;
  logic        aw_held;
  logic        w_held;
  logic [31:2] awaddr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] regs [4];

  logic        aw_hs;
  logic        w_hs;
  logic        aw_full;
  logic        w_full;
  logic        hit;
  logic [1:0]  idx;
  logic        addr_lsb_unused;

  assign addr_lsb_unused = ^AWADDR[1:0];

  always_comb begin
    aw_hs   = AWVALID & AWREADY & (state == IDLE);
    w_hs    = WVALID & WREADY & (state == IDLE);
    aw_full = aw_held | aw_hs;
    w_full  = w_held | w_hs;
    hit     = (awaddr_q[31:4] == BASE_ADDR[31:4]);
    idx     = awaddr_q[3:2];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      Reg_Wr   <= '0;
      for (int unsigned i = 0; i < 4; i++) regs[i] <= '0;
`ifdef AXIL_BRESP_EN
      BVALID   <= 1'b0;
      BRESP    <= 2'b00;
`endif
    end else begin
      Reg_Wr <= '0;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            awaddr_q <= AWADDR[31:2];
            aw_held  <= 1'b1;
          end
          if (w_hs) begin
            wdata_q <= WDATA;
            wstrb_q <= WSTRB;
            w_held  <= 1'b1;
          end
          // Ready drops on the accepting edge so each channel takes one beat.
          if (aw_full && w_full) begin
            state   <= WRITE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
          end else begin
            AWREADY <= ~aw_full;
            WREADY  <= ~w_full;
          end
        end
        WRITE: begin
          if (hit) begin
            for (int unsigned b = 0; b < 4; b++)
              if (wstrb_q[b[1:0]]) regs[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            Reg_Wr[idx] <= 1'b1;
          end
          aw_held <= 1'b0;
          w_held  <= 1'b0;
`ifdef AXIL_BRESP_EN
          BRESP  <= hit ? 2'b00 : 2'b10;
          BVALID <= 1'b1;
          state  <= RESP;
`else
          state   <= IDLE;
          AWREADY <= 1'b1;
          WREADY  <= 1'b1;
`endif
        end
`ifdef AXIL_BRESP_EN
        RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            state   <= IDLE;
            AWREADY <= 1'b1;
            WREADY  <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign Reg0_Out = regs[0];
  assign Reg1_Out = regs[1];
  assign Reg2_Out = regs[2];
  assign Reg3_Out = regs[3];

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Randomized self-checking bench for axi_lite_write_slave against a register-bank model.
// Works with or without AXIL_BRESP_EN defined.
module tb_axi_lite_write_slave;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] AWADDR = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
`ifdef AXIL_BRESP_EN
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;
`endif
  logic [31:0] Reg0_Out, Reg1_Out, Reg2_Out, Reg3_Out;
  logic [3:0]  Reg_Wr;

  axi_lite_write_slave #(.BASE_ADDR(BASE)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
`ifdef AXIL_BRESP_EN
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
`endif
    .Reg0_Out(Reg0_Out), .Reg1_Out(Reg1_Out), .Reg2_Out(Reg2_Out), .Reg3_Out(Reg3_Out),
    .Reg_Wr(Reg_Wr)
  );

  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;
  logic [31:0] model [4];
  logic [31:0] outs [4];

  always_comb begin
    outs[0] = Reg0_Out;
    outs[1] = Reg1_Out;
    outs[2] = Reg2_Out;
    outs[3] = Reg3_Out;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s_reg%0d", tag, i), outs[i], model[i]);
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input int dly, output int hs);
    int n;
    repeat (dly) tick();
    AWVALID = 1'b1;
    AWADDR  = addr;
    n = 0;
    while (AWREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      check_eq("aw_timeout", 32'd0, 32'd1);
      hs = -1;
    end else begin
      tick();
      hs = cyc;
      check_eq("awready_after_hs", {31'd0, AWREADY}, 32'd0);
    end
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int dly, output int hs);
    int n;
    repeat (dly) tick();
    WVALID = 1'b1;
    WDATA  = data;
    WSTRB  = strb;
    n = 0;
    while (WREADY !== 1'b1 && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      check_eq("w_timeout", 32'd0, 32'd1);
      hs = -1;
    end else begin
      tick();
      hs = cyc;
      check_eq("wready_after_hs", {31'd0, WREADY}, 32'd0);
    end
    WVALID = 1'b0;
  endtask

  // Model: a hit overwrites strobed bytes of word addr[3:2]; a miss changes nothing.
  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [3:0] exp_wr,
                             output logic [1:0] exp_resp);
    int i;
    i = int'(addr[3:2]);
    if (addr[31:4] == BASE[31:4]) begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model[i][8*b +: 8] = data[8*b +: 8];
      exp_wr   = 4'b0001 << i;
      exp_resp = 2'b00;
    end else begin
      exp_wr   = 4'b0000;
      exp_resp = 2'b10;
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int hs_a, hs_w;
    logic [3:0] exp_wr;
    logic [1:0] exp_resp;
    fork
      send_aw(addr, aw_dly, hs_a);
      send_w(data, strb, w_dly, hs_w);
    join
    check_eq("awready_in_write", {31'd0, AWREADY}, 32'd0);
    check_eq("wready_in_write", {31'd0, WREADY}, 32'd0);
    model_write(addr, data, strb, exp_wr, exp_resp);
`ifdef AXIL_BRESP_EN
    BREADY = (b_dly == 0);
`endif
    tick();
    check_eq("reg_wr_pulse", {28'd0, Reg_Wr}, {28'd0, exp_wr});
    check_regs("write");
`ifdef AXIL_BRESP_EN
    check_eq("bvalid_rise", {31'd0, BVALID}, 32'd1);
    check_eq("bresp", {30'd0, BRESP}, {30'd0, exp_resp});
    repeat (b_dly) begin
      check_eq("bvalid_hold", {31'd0, BVALID}, 32'd1);
      check_eq("bresp_hold", {30'd0, BRESP}, {30'd0, exp_resp});
      check_eq("awready_in_resp", {31'd0, AWREADY}, 32'd0);
      check_eq("wready_in_resp", {31'd0, WREADY}, 32'd0);
      tick();
    end
    BREADY = 1'b1;
    tick();
    BREADY = 1'b0;
    check_eq("bvalid_fall", {31'd0, BVALID}, 32'd0);
`else
    if (b_dly < 0) $display("unexpected response delay");
    tick();
`endif
    check_eq("reg_wr_one_cycle", {28'd0, Reg_Wr}, 32'd0);
    check_eq("awready_back", {31'd0, AWREADY}, 32'd1);
    check_eq("wready_back", {31'd0, WREADY}, 32'd1);
  endtask

  task automatic back_to_back();
    int t0, t1, n, gap;
    logic [31:0] d0, d1;
    logic [3:0] ew;
    logic [1:0] er;
    d0 = $urandom;
    d1 = $urandom;
`ifdef AXIL_BRESP_EN
    BREADY = 1'b1;
    gap = 3;
`else
    gap = 2;
`endif
    AWVALID = 1'b1; AWADDR = 32'h0; WVALID = 1'b1; WDATA = d0; WSTRB = 4'hF;
    n = 0;
    while (!(AWREADY === 1'b1 && WREADY === 1'b1) && n < 20) begin tick(); n++; end
    tick();
    t0 = cyc;
    model_write(32'h0, d0, 4'hF, ew, er);
    AWADDR = 32'h8; WDATA = d1;
    n = 0;
    while (!(AWREADY === 1'b1 && WREADY === 1'b1) && n < 20) begin tick(); n++; end
    tick();
    t1 = cyc;
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("b2b_gap", t1 - t0, gap);
    check_eq("b2b_reg0", Reg0_Out, model[0]);
    model_write(32'h8, d1, 4'hF, ew, er);
    tick();
    check_eq("b2b_reg_wr", {28'd0, Reg_Wr}, {28'd0, ew});
    check_regs("b2b");
`ifdef AXIL_BRESP_EN
    tick();
    BREADY = 1'b0;
`endif
    check_eq("b2b_awready", {31'd0, AWREADY}, 32'd1);
  endtask

  task automatic reset_abandon();
    int n;
    AWVALID = 1'b1; AWADDR = 32'h8;
    n = 0;
    while (AWREADY !== 1'b1 && n < 20) begin tick(); n++; end
    tick();
    AWVALID = 1'b0;
    check_eq("rst_aw_held", {31'd0, AWREADY}, 32'd0);
    ARESET = 1'b1; WVALID = 1'b1; WDATA = $urandom | 32'h1; WSTRB = 4'hF;
    tick();
    for (int i = 0; i < 4; i++) model[i] = '0;
    check_eq("rst_reg_wr", {28'd0, Reg_Wr}, 32'd0);
    check_eq("rst_awready", {31'd0, AWREADY}, 32'd0);
    check_eq("rst_wready", {31'd0, WREADY}, 32'd0);
    check_regs("rst");
    ARESET = 1'b0; WVALID = 1'b0;
    tick();
    check_eq("rst_rel_awready", {31'd0, AWREADY}, 32'd1);
    check_eq("rst_rel_wready", {31'd0, WREADY}, 32'd1);
    check_eq("rst_rel_reg_wr", {28'd0, Reg_Wr}, 32'd0);
    check_regs("rst_rel");
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 4; i++) model[i] = '0;
    repeat (3) tick();
    check_eq("reset_awready", {31'd0, AWREADY}, 32'd0);
    check_eq("reset_wready", {31'd0, WREADY}, 32'd0);
    check_eq("reset_reg_wr", {28'd0, Reg_Wr}, 32'd0);
    check_regs("reset");
`ifdef AXIL_BRESP_EN
    check_eq("reset_bvalid", {31'd0, BVALID}, 32'd0);
    check_eq("reset_bresp", {30'd0, BRESP}, 32'd0);
`endif
    ARESET = 1'b0;
    tick();
    check_eq("release_awready", {31'd0, AWREADY}, 32'd1);
    check_eq("release_wready", {31'd0, WREADY}, 32'd1);

    do_write(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    check_eq("same_cycle_reg1", Reg1_Out, 32'hDEADBEEF);
    do_write(32'hC, 32'h11223344, 4'b0101, 3, 0, 0);
    check_eq("w_first_reg3", Reg3_Out, 32'h00220044);
    do_write(32'h20, $urandom, 4'hF, 0, 0, 0);
    do_write(32'h8, $urandom, 4'hF, 0, 0, 5);
    do_write(32'h0, $urandom, 4'h0, 1, 0, 0);

    for (int t = 0; t < 40; t++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a = a & 32'h0000_000F;
      else if (a[31:4] == BASE[31:4]) a = a | 32'h8000_0000;
      do_write(a, $urandom, 4'($urandom_range(0, 15)),
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    back_to_back();
    reset_abandon();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axi_lite_write_slave.md
AXI_LITE_WRITE_SLAVE -- requirements
Module: axi_lite_write_slave

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, base of the 16-byte register window; bits [3:0] SHALL be ignored.
REQ-002 ACLK  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 ARESET  input  1  synchronous, active-high reset.
REQ-004 AWVALID  input  1  write-address valid from the master.
REQ-005 AWREADY  output  1  write-address ready, registered.
REQ-006 AWADDR  input  32  byte address of the write.
REQ-007 WVALID  input  1  write-data valid.
REQ-008 WREADY  output  1  write-data ready, registered.
REQ-009 WDATA  input  32  write data.
REQ-010 WSTRB  input  4  byte enables; bit i SHALL qualify WDATA[8i+7:8i].
REQ-011 BVALID, BREADY, BRESP  output/input/output  1/1/2  write-response channel; present only per REQ-031.
REQ-012 Reg0_Out..Reg3_Out  output  32 each  register bank contents at offsets 0x0, 0x4, 0x8, 0xC.
REQ-013 Reg_Wr  output  4  one-hot, one-cycle pulse marking which register was just updated.

Function
REQ-014 The FSM SHALL have states IDLE, WRITE and RESP; RESP exists only when AXIL_BRESP_EN is defined.
REQ-015 In IDLE, AWREADY SHALL be 1 while no address is held, and WREADY SHALL be 1 while no data is held.
REQ-016 A channel handshake SHALL occur on a rising edge with VALID=1 and READY=1; AWADDR or WDATA+WSTRB SHALL be captured, and that READY SHALL be 0 from the next cycle.
REQ-017 AW and W SHALL be accepted in either order or in the same cycle; a held beat SHALL wait indefinitely for its partner.
REQ-018 On the edge where both beats are held, the FSM SHALL enter WRITE with AWREADY=WREADY=0.
REQ-019 Decode: hit when AWADDR[31:4]==BASE_ADDR[31:4]; index = AWADDR[3:2]; AWADDR[1:0] ignored.
REQ-020 At the edge leaving WRITE, a hit SHALL update only the strobed bytes of the indexed register and pulse the matching Reg_Wr bit for exactly one cycle.
REQ-021 A miss SHALL change no register, leave Reg_Wr=0 and record SLVERR (2'b10); a hit SHALL record OKAY (2'b00).
REQ-022 WSTRB=4'b0000 on a hit SHALL leave the register unchanged but still pulse Reg_Wr and record OKAY.
REQ-023 Latency: the register value and Reg_Wr pulse SHALL be visible one cycle after the edge completing the second handshake.
REQ-024 With the response enabled, WRITE SHALL go to RESP and drive BVALID=1 with BRESP held stable until an edge with BREADY=1, then go to IDLE with BVALID=0.
REQ-025 BREADY already high when BVALID rises SHALL complete RESP in one cycle.
REQ-026 After returning to IDLE, AWREADY and WREADY SHALL both be 1 on the following cycle; at most one transaction SHALL be outstanding.

Reset
REQ-027 ARESET=1 at an edge SHALL force IDLE, clear held beats, and drive AWREADY=0, WREADY=0, BVALID=0, BRESP=2'b00, Reg_Wr=0 and Reg0_Out..Reg3_Out=0.
REQ-028 AWREADY and WREADY SHALL become 1 on the first edge with ARESET=0.
REQ-029 Reset in any state SHALL abandon the transaction with no register write, no Reg_Wr pulse and no response.

Configuration
REQ-030 The macro AXIL_BRESP_EN SHALL select whether the write-response channel is built.
REQ-031 With AXIL_BRESP_EN defined, the BVALID, BREADY and BRESP ports and the RESP state SHALL exist.
REQ-032 Without AXIL_BRESP_EN, those ports SHALL be absent and WRITE SHALL return directly to IDLE; the decode-miss status SHALL be discarded.

Verification
REQ-033 Same-cycle AW=0x4, W=0xDEADBEEF, WSTRB=4'hF -> Reg1_Out=0xDEADBEEF, Reg_Wr=4'b0010 for 1 cycle, BRESP=OKAY.
REQ-034 W (0x11223344, WSTRB=4'b0101) issued 3 cycles before AW=0xC, Reg3_Out=0 -> Reg3_Out=0x00220044, WREADY=0 while waiting.
REQ-035 AW=0x20 with BASE_ADDR=0 -> no register changes, Reg_Wr=0, BRESP=2'b10.
REQ-036 BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 throughout, ready again 1 cycle after the BREADY handshake.
REQ-037 ARESET pulsed with AW held and W pending -> all registers 0, no Reg_Wr pulse, AWREADY=WREADY=1 one cycle after release.
REQ-038 Build without AXIL_BRESP_EN, back-to-back writes to 0x0 and 0x8 -> both registers updated, second handshake accepted 2 cycles after the first.
